prog_field_seq: RTL and testbench
=================================

Name: prog_field_seq

Overview:
- Programming-mode sequencer for the clock/date/timer edit datapath.
- Steps through the editable RTC fields of one group: time, date or timer.
- For each field it drives the field selector, the counter load strobe and the counter limit.
- When the user commits a field, it writes the edited BCD value to the RTC bus interface with a req/ack handshake.
- Sits between the debounced push-button logic and the field edit datapath / RTC write port.

Parameters:
- ACK_TIMEOUT, 255, cycles to wait for wr_ack before aborting the write (8-bit counter, must be 1..255).
- ADDR_BASE_T, 8'h21, RTC address of the seconds register; time fields use +0/+1/+2 (seg/min/hora).
- ADDR_BASE_D, 8'h24, RTC address of the day register; date fields use +0/+1/+2 (day/month/year).
- ADDR_BASE_TM, 8'h41, RTC address of the timer seconds register; timer fields use +0/+1/+2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- PB_prog  in  1  single-cycle pulse: enter programming / commit-and-exit
- PB_next  in  1  single-cycle pulse: commit current field, advance to next
- grp_sel  in  2  00 time, 01 date, 10 timer, 11 reserved (ignored)
- SF_24_12  in  1  1 = 24 h format, 0 = 12 h format
- month_BCD  in  8  current month (used only with DAY_LIMIT_EN)
- year_BCD  in  8  current year (used only with DAY_LIMIT_EN)
- Wr_BCD  in  8  edited field value from the edit datapath
- wr_ack  in  1  RTC interface write acknowledge (1-cycle pulse)
- sel_LD  out  4  field select: 0 seg, 1 min, 2 hora, 3 day, 4 month, 5 year, 6 seg_t, 7 min_t, 8 hora_t
- Num_Ld  out  1  1-cycle load strobe to the edit counter
- Cont_max  out  7  counter upper limit, binary
- prog_on  out  1  high while in programming mode
- wr_req  out  1  write request, held until wr_ack or timeout
- wr_addr  out  8  RTC register address
- wr_data  out  8  BCD data to write
- wr_err  out  1  sticky; set on ack timeout, cleared on the next PB_prog entry

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, idx=0, all outputs 0 (sel_LD=0, Cont_max=0, wr_addr=0, wr_data=0).
- States: IDLE, LOAD, EDIT, WRITE, DONE.
- IDLE: PB_prog with grp_sel!=11 latches the group, sets idx=0 → LOAD. PB_next is ignored.
- LOAD: Num_Ld=1 for exactly one cycle → EDIT.
  - sel_LD and Cont_max become valid in the LOAD cycle and stay stable through EDIT and WRITE.
- EDIT: prog_on=1.
  - PB_next: set last=0 → WRITE.
  - PB_prog: set last=1 → WRITE.
  - Both pulses in the same cycle: PB_prog wins.
- WRITE:
  - On entry, wr_data ← Wr_BCD (sampled once) and wr_addr ← base+idx.
  - wr_req=1 until the cycle wr_ack=1, then drops the following cycle.
  - If the timer reaches ACK_TIMEOUT: drop wr_req, set wr_err, → IDLE.
  - On ack: if last=1 or idx==2 → DONE; otherwise idx+1 → LOAD.
  - PB pulses are ignored in WRITE.
- DONE: one cycle, prog_on=0 → IDLE.
- prog_on is 1 in LOAD, EDIT and WRITE.
- sel_LD = 3*grp + idx.
- Cont_max per field:
  - seg and min: 59
  - hora: 23 if SF_24_12 else 12
  - day: 31
  - month: 12
  - year: 99
  - timer fields: same as seg/min/hora
- SF_24_12 is sampled continuously. A change during EDIT updates Cont_max combinationally on the next cycle; no reload.
- A reset during WRITE drops wr_req in the same edge; no partial write is retried.

Optional Feature:
- Macro DAY_LIMIT_EN.
- Defined: the day Cont_max is month-dependent, from month_BCD/year_BCD converted to binary.
  - 30 for months 4, 6, 9, 11.
  - 29 for month 2 when year%4==0, otherwise 28.
  - 31 for all other months.
  - Invalid months (0, >12) give 31.
  - Evaluated when day is selected and registered in LOAD.
- Undefined: day limit is fixed at 31; month_BCD/year_BCD are unused.

Test Plan:
- Reset low 2 cycles, then high → all outputs 0, state IDLE; PB_next pulse → no change.
- grp_sel=00, PB_prog → Num_Ld pulse with sel_LD=0, Cont_max=59; Wr_BCD=8'h45, PB_next → wr_req, wr_addr=8'h21, wr_data=8'h45; ack after 3 cycles → LOAD with sel_LD=1.
- grp_sel=10, SF_24_12=0: advance to hora_t → sel_LD=8, Cont_max=12, wr_addr=8'h43; after its ack → DONE, then IDLE with prog_on=0.
- Date group at month, PB_prog and PB_next in the same cycle → single write of month to 8'h25, then exit to IDLE.
- wr_ack never asserted, ACK_TIMEOUT=255 → wr_req drops after 255 cycles and wr_err=1; next PB_prog clears wr_err.
- DAY_LIMIT_EN defined, month_BCD=8'h02 and year_BCD=8'h24, select day → Cont_max=29; with year_BCD=8'h23 → 28; with month_BCD=8'h11 → 30.

Source files
------------

// File: rtl/prog_field_seq.sv
// Programming-mode sequencer: steps through time/date/timer fields and writes each edited BCD value to the RTC.
// Optional macro DAY_LIMIT_EN: day limit depends on month_BCD/year_BCD (leap year = year%4==0).
module prog_field_seq #(
  parameter logic [7:0] ACK_TIMEOUT  = 8'd255,
  parameter logic [7:0] ADDR_BASE_T  = 8'h21,
  parameter logic [7:0] ADDR_BASE_D  = 8'h24,
  parameter logic [7:0] ADDR_BASE_TM = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PB_prog,
  input  logic       PB_next,
  input  logic [1:0] grp_sel,
  input  logic       SF_24_12,
  input  logic [7:0] month_BCD,
  input  logic [7:0] year_BCD,
  input  logic [7:0] Wr_BCD,
  input  logic       wr_ack,
  output logic [3:0] sel_LD,
  output logic       Num_Ld,
  output logic [6:0] Cont_max,
  output logic       prog_on,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_err
);

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CMAX_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned GRP_W  = 2;
  localparam logic [DATA_W-1:0] TIMEOUT_LAST = ACK_TIMEOUT - 8'd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EDIT, S_WRITE, S_DONE} state_t;

  state_t              state, state_n;
  logic [GRP_W-1:0]    grp, grp_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                last, last_n;
  logic [DATA_W-1:0]   timer, timer_n;
  logic [SEL_W-1:0]    sel_n;
  logic [CMAX_W-1:0]   cmax_n;
  logic                num_ld_n, prog_on_n, wr_req_n, wr_err_n;
  logic [DATA_W-1:0]   wr_addr_n, wr_data_n;
  logic [CMAX_W-1:0]   day_lim_c;

  // Upper counter limit for a field; day limit is supplied by the caller.
  function automatic logic [CMAX_W-1:0] field_limit(input logic [SEL_W-1:0] sel,
                                                    input logic sf24,
                                                    input logic [CMAX_W-1:0] day_lim);
    case (sel)
      4'd0, 4'd1, 4'd6, 4'd7: field_limit = 7'd59;
      4'd2, 4'd8:             field_limit = sf24 ? 7'd23 : 7'd12;
      4'd3:                   field_limit = day_lim;
      4'd4:                   field_limit = 7'd12;
      4'd5:                   field_limit = 7'd99;
      default:                field_limit = 7'd0;
    endcase
  endfunction

`ifdef DAY_LIMIT_EN
  logic [CMAX_W-1:0] month_bin, year_bin;

  function automatic logic [CMAX_W-1:0] bcd2bin(input logic [DATA_W-1:0] b);
    bcd2bin = CMAX_W'(b[7:4]) * 7'd10 + CMAX_W'(b[3:0]);
  endfunction

  assign month_bin = bcd2bin(month_BCD);
  assign year_bin  = bcd2bin(year_BCD);

  // Days in the current month; out-of-range months fall back to 31.
  always_comb begin
    day_lim_c = 7'd31;
    case (month_bin)
      7'd4, 7'd6, 7'd9, 7'd11: day_lim_c = 7'd30;
      7'd2:                    day_lim_c = ((year_bin % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
      default:                 day_lim_c = 7'd31;
    endcase
  end
`else
  logic unused_date_in;
  assign unused_date_in = ^{month_BCD, year_BCD};
  assign day_lim_c = 7'd31;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      grp      <= '0;
      idx      <= '0;
      last     <= 1'b0;
      timer    <= '0;
      sel_LD   <= '0;
      Num_Ld   <= 1'b0;
      Cont_max <= '0;
      prog_on  <= 1'b0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_err   <= 1'b0;
    end else begin
      state    <= state_n;
      grp      <= grp_n;
      idx      <= idx_n;
      last     <= last_n;
      timer    <= timer_n;
      sel_LD   <= sel_n;
      Num_Ld   <= num_ld_n;
      Cont_max <= cmax_n;
      prog_on  <= prog_on_n;
      wr_req   <= wr_req_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      wr_err   <= wr_err_n;
    end
  end

  // Next state, then outputs derived from the state being entered.
  always_comb begin
    state_n   = state;
    grp_n     = grp;
    idx_n     = idx;
    last_n    = last;
    timer_n   = timer;
    sel_n     = sel_LD;
    cmax_n    = Cont_max;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    wr_err_n  = wr_err;

    case (state)
      S_IDLE: begin
        if (PB_prog && (grp_sel != 2'b11)) begin
          grp_n    = grp_sel;
          idx_n    = '0;
          wr_err_n = 1'b0;
          state_n  = S_LOAD;
        end
      end
      S_LOAD: state_n = S_EDIT;
      S_EDIT: begin
        if (PB_prog) begin
          last_n  = 1'b1;
          state_n = S_WRITE;
        end else if (PB_next) begin
          last_n  = 1'b0;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          if (last || (idx == 2'd2)) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = S_LOAD;
          end
        end else if (timer == TIMEOUT_LAST) begin
          wr_err_n = 1'b1;
          state_n  = S_IDLE;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    num_ld_n  = (state_n == S_LOAD);
    prog_on_n = (state_n == S_LOAD) || (state_n == S_EDIT) || (state_n == S_WRITE);
    wr_req_n  = (state_n == S_WRITE);

    // Capture address/data exactly once, on entry to WRITE.
    if ((state_n == S_WRITE) && (state != S_WRITE)) begin
      wr_data_n = Wr_BCD;
      timer_n   = '0;
      case (grp_n)
        2'd0:    wr_addr_n = ADDR_BASE_T + DATA_W'(idx_n);
        2'd1:    wr_addr_n = ADDR_BASE_D + DATA_W'(idx_n);
        default: wr_addr_n = ADDR_BASE_TM + DATA_W'(idx_n);
      endcase
    end

    // Day limit is frozen at LOAD; hour limit follows SF_24_12 while active.
    if (state_n == S_LOAD) begin
      sel_n  = SEL_W'(grp_n) * 4'd3 + SEL_W'(idx_n);
      cmax_n = field_limit(sel_n, SF_24_12, day_lim_c);
    end else if (prog_on_n) begin
      cmax_n = field_limit(sel_LD, SF_24_12, Cont_max);
    end
  end

endmodule

// File: tb/tb_prog_field_seq.sv
// Directed self-checking bench for prog_field_seq (define DAY_LIMIT_EN to also cover month-dependent day limits).
module tb_prog_field_seq;

  logic       clk;
  logic       reset;
  logic       PB_prog, PB_next;
  logic [1:0] grp_sel;
  logic       SF_24_12;
  logic [7:0] month_BCD, year_BCD, Wr_BCD;
  logic       wr_ack;
  logic [3:0] sel_LD;
  logic       Num_Ld;
  logic [6:0] Cont_max;
  logic       prog_on, wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_err;

  int n_chk  = 0;
  int n_pass = 0;

  prog_field_seq dut (
    .clk(clk), .reset(reset), .PB_prog(PB_prog), .PB_next(PB_next),
    .grp_sel(grp_sel), .SF_24_12(SF_24_12), .month_BCD(month_BCD),
    .year_BCD(year_BCD), .Wr_BCD(Wr_BCD), .wr_ack(wr_ack),
    .sel_LD(sel_LD), .Num_Ld(Num_Ld), .Cont_max(Cont_max), .prog_on(prog_on),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

`ifdef DAY_LIMIT_EN
  task automatic day_case(input logic [7:0] mon, input logic [7:0] yr, input logic [7:0] exp);
    month_BCD = mon; year_BCD = yr; grp_sel = 2'd1;
    PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("day_sel", 8'(sel_LD), 8'd3);
    chk("day_limit", 8'(Cont_max), exp);
    tick();
    PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    tick();
    chk("day_exit", 8'(prog_on), 8'd0);
  endtask
`endif

  initial begin
    reset = 1'b0; PB_prog = 1'b0; PB_next = 1'b0; grp_sel = 2'd0; SF_24_12 = 1'b1;
    month_BCD = 8'h00; year_BCD = 8'h00; Wr_BCD = 8'h00; wr_ack = 1'b0;

    // reset
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_sel", 8'(sel_LD), 8'd0);
    chk("rst_numld", 8'(Num_Ld), 8'd0);
    chk("rst_cmax", 8'(Cont_max), 8'd0);
    chk("rst_progon", 8'(prog_on), 8'd0);
    chk("rst_wrreq", 8'(wr_req), 8'd0);
    chk("rst_addr", wr_addr, 8'h00);
    chk("rst_data", wr_data, 8'h00);
    chk("rst_err", 8'(wr_err), 8'd0);
    PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("idle_next_progon", 8'(prog_on), 8'd0);
    chk("idle_next_numld", 8'(Num_Ld), 8'd0);
    tick();
    chk("idle_next_wrreq", 8'(wr_req), 8'd0);

    // time group: seconds write with delayed ack
    grp_sel = 2'd0; PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("t_load_numld", 8'(Num_Ld), 8'd1);
    chk("t_load_sel", 8'(sel_LD), 8'd0);
    chk("t_load_cmax", 8'(Cont_max), 8'd59);
    chk("t_load_progon", 8'(prog_on), 8'd1);
    tick();
    chk("t_edit_numld", 8'(Num_Ld), 8'd0);
    Wr_BCD = 8'h45; PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("t_wr_req", 8'(wr_req), 8'd1);
    chk("t_wr_addr", wr_addr, 8'h21);
    chk("t_wr_data", wr_data, 8'h45);
    Wr_BCD = 8'h99; PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    tick();
    chk("t_wr_hold_req", 8'(wr_req), 8'd1);
    chk("t_wr_hold_data", wr_data, 8'h45);
    chk("t_wr_hold_sel", 8'(sel_LD), 8'd0);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("t_ack_wrreq", 8'(wr_req), 8'd0);
    chk("t_ack_numld", 8'(Num_Ld), 8'd1);
    chk("t_ack_sel", 8'(sel_LD), 8'd1);
    chk("t_ack_cmax", 8'(Cont_max), 8'd59);
    tick();
    PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("t_min_addr", wr_addr, 8'h22);
    chk("t_min_data", wr_data, 8'h99);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("t_done_progon", 8'(prog_on), 8'd0);
    chk("t_done_wrreq", 8'(wr_req), 8'd0);
    tick();
    chk("t_idle_progon", 8'(prog_on), 8'd0);
    chk("t_idle_numld", 8'(Num_Ld), 8'd0);

    // timer group, 12 h format, walk to hora_t
    grp_sel = 2'd2; SF_24_12 = 1'b0; PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("tm_sel0", 8'(sel_LD), 8'd6);
    chk("tm_cmax0", 8'(Cont_max), 8'd59);
    tick();
    PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("tm_addr0", wr_addr, 8'h41);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("tm_sel1", 8'(sel_LD), 8'd7);
    tick();
    PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("tm_addr1", wr_addr, 8'h42);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("tm_sel2", 8'(sel_LD), 8'd8);
    chk("tm_cmax2_12h", 8'(Cont_max), 8'd12);
    tick();
    SF_24_12 = 1'b1; tick();
    chk("tm_cmax2_24h", 8'(Cont_max), 8'd23);
    chk("tm_no_reload", 8'(Num_Ld), 8'd0);
    SF_24_12 = 1'b0; tick();
    chk("tm_cmax2_back", 8'(Cont_max), 8'd12);
    PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("tm_addr2", wr_addr, 8'h43);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("tm_done_progon", 8'(prog_on), 8'd0);
    chk("tm_done_numld", 8'(Num_Ld), 8'd0);
    tick();
    chk("tm_idle_numld", 8'(Num_Ld), 8'd0);
    chk("tm_idle_progon", 8'(prog_on), 8'd0);

    // date group: exit at month with both buttons in the same cycle
    grp_sel = 2'd1; PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("d_sel0", 8'(sel_LD), 8'd3);
    chk("d_cmax0", 8'(Cont_max), 8'd31);
    tick();
    PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("d_addr0", wr_addr, 8'h24);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("d_sel1", 8'(sel_LD), 8'd4);
    chk("d_cmax1", 8'(Cont_max), 8'd12);
    tick();
    Wr_BCD = 8'h12; PB_prog = 1'b1; PB_next = 1'b1; tick(); PB_prog = 1'b0; PB_next = 1'b0;
    chk("d_both_addr", wr_addr, 8'h25);
    chk("d_both_data", wr_data, 8'h12);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("d_done_progon", 8'(prog_on), 8'd0);
    chk("d_done_numld", 8'(Num_Ld), 8'd0);
    tick();
    chk("d_idle_wrreq", 8'(wr_req), 8'd0);
    chk("d_idle_progon", 8'(prog_on), 8'd0);

    // reserved group ignored
    grp_sel = 2'd3; PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("rsv_progon", 8'(prog_on), 8'd0);
    chk("rsv_numld", 8'(Num_Ld), 8'd0);

    // ack timeout
    grp_sel = 2'd0; PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    tick();
    PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("to_req_first", 8'(wr_req), 8'd1);
    for (int i = 0; i < 254; i++) tick();
    chk("to_req_last", 8'(wr_req), 8'd1);
    chk("to_err_before", 8'(wr_err), 8'd0);
    tick();
    chk("to_req_drop", 8'(wr_req), 8'd0);
    chk("to_err_set", 8'(wr_err), 8'd1);
    chk("to_progon", 8'(prog_on), 8'd0);
    tick();
    chk("to_err_sticky", 8'(wr_err), 8'd1);
    PB_prog = 1'b1; tick(); PB_prog = 1'b0;
    chk("to_err_clear", 8'(wr_err), 8'd0);
    chk("to_reenter", 8'(Num_Ld), 8'd1);

    // reset during write
    tick();
    Wr_BCD = 8'h33; PB_next = 1'b1; tick(); PB_next = 1'b0;
    chk("rw_req", 8'(wr_req), 8'd1);
    reset = 1'b0; tick();
    chk("rw_req_drop", 8'(wr_req), 8'd0);
    chk("rw_addr", wr_addr, 8'h00);
    reset = 1'b1; wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("rw_no_retry", 8'(wr_req), 8'd0);
    chk("rw_progon", 8'(prog_on), 8'd0);

`ifdef DAY_LIMIT_EN
    day_case(8'h02, 8'h24, 8'd29);
    day_case(8'h02, 8'h23, 8'd28);
    day_case(8'h11, 8'h23, 8'd30);
    day_case(8'h13, 8'h23, 8'd31);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
